zmips_dmem: RTL and testbench

- Data-memory responder sitting on the zmips core's data bus (d_addr, d_data, d_rd, d_wr).
- Services word reads and writes to an on-chip RAM after a configurable number of wait states.
- Flags misaligned, out-of-window and read+write-collision requests as errors.
- Is the far end of the core's data port; the core (or a bench) is the initiator.

---
 rtl/zmips_dmem_if.sv | 28 ++
 rtl/zmips_dmem.sv | 149 ++++++++++++++
 tb/tb_zmips_dmem.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zmips_dmem_if.sv
// -----------------------------------------------------------------------------
// zmips_dmem_if
// Request/response signals of the zmips core data bus (without the data lane).
//   d_addr : byte address, driven by the initiator
//   d_rd   : read strobe, held by the initiator until d_rdy
//   d_wr   : write strobe, held by the initiator until d_rdy
//   d_rdy  : one-cycle response pulse from the responder
//   d_err  : error qualifier, meaningful only while d_rdy is high
// The bidirectional d_data lane is a plain module port. This keeps it an
// ordinary resolved net at the top level.
// -----------------------------------------------------------------------------
interface zmips_dmem_if;
  logic [31:0] d_addr;
  logic        d_rd;
  logic        d_wr;
  logic        d_rdy;
  logic        d_err;

  modport master (
    output d_addr, d_rd, d_wr,
    input  d_rdy, d_err
  );

  modport slave (
    input  d_addr, d_rd, d_wr,
    output d_rdy, d_err
  );
endinterface

// File: rtl/zmips_dmem.sv
// -----------------------------------------------------------------------------
// zmips_dmem
// Data-memory responder for the zmips core data port. It accepts a word read
// or write in IDLE and optionally spends WAIT_CYCLES cycles in WAIT. It then
// answers with a single-cycle RESP (d_rdy=1). The following requests are
// errors and never touch the RAM:
//   - misaligned requests
//   - requests outside the RAM window
//   - requests with both strobes set
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset (RAM contents are kept)
//   bus    : zmips_dmem_if.slave (d_addr, d_rd, d_wr in; d_rdy, d_err out)
//   d_data : bidirectional data. It carries write data from the initiator.
//            This block drives it only during the RESP cycle of a read.
// -----------------------------------------------------------------------------
module zmips_dmem #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  zmips_dmem_if.slave       bus,
  inout  wire  [31:0]       d_data
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;

  // Request captured at accept time. Bus changes after accept are ignored.
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       mem [DEPTH];

  logic              req;
  logic              req_err;
  logic              go_resp;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_wr;
  logic              acc_err;

  assign req     = bus.d_rd | bus.d_wr;
  assign req_err = (bus.d_rd & bus.d_wr)
                 | (bus.d_addr[1:0] != 2'b00)
                 | (bus.d_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    go_resp  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_nx = S_WAIT;
          end else begin
            state_nx = S_RESP;
            go_resp  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESP;
          go_resp  = 1'b1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states, the edge that enters RESP is also the accept edge.
  // The operands must then come straight from the bus instead of the latches.
  always_comb begin
    if (state == S_IDLE) begin
      acc_idx   = bus.d_addr[ADDR_W+1:2];
      acc_wdata = d_data;
      acc_wr    = bus.d_wr;
      acc_err   = req_err;
    end else begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_wr    = wr_q;
      acc_err   = err_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req) begin
        idx_q   <= bus.d_addr[ADDR_W+1:2];
        wdata_q <= d_data;
        rd_q    <= bus.d_rd;
        wr_q    <= bus.d_wr;
        err_q   <= req_err;
        cnt     <= WAIT_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // NOTE: the RAM array is deliberately not reset. rst only blocks the commit
  // edge, so an access aborted by reset leaves memory untouched.
  always_ff @(posedge clk) begin
    if (!rst && go_resp) begin
      if (acc_wr && !acc_err) begin
        mem[acc_idx] <= acc_wdata;
      end
      rdata_q <= mem[acc_idx];
    end
  end

  assign bus.d_rdy = (state == S_RESP);
  assign bus.d_err = (state == S_RESP) & err_q;

  // A collision (both strobes set) counts as a write here, so the lane stays released.
  assign d_data = (state == S_RESP && rd_q && !wr_q) ? (err_q ? 32'h0000_0000 : rdata_q)
                                                     : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_zmips_dmem.sv
// -----------------------------------------------------------------------------
// tb_zmips_dmem
// Three responders share one clock:
//   unit 0 : WAIT_CYCLES=1
//   unit 1 : WAIT_CYCLES=0
//   unit 2 : WAIT_CYCLES=3
// Stimulus tasks predict each response from a word-addressed reference memory
// and push it onto a scoreboard. A negedge monitor pops one entry per d_rdy
// pulse and checks the cycle it arrived, d_err and d_data. While the
// initiator drives write data, d_data must still show that value in RESP.
// -----------------------------------------------------------------------------
module tb_zmips_dmem;

  localparam int          NU     = 3;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          WINDOW = 4 * 1024;

  typedef struct {
    int          unit;
    int          due;
    bit          err;
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic        clk;
  int          cyc;
  int          checks;
  int          errors;
  exp_t        sb[$];
  logic [31:0] model_mem [int];
  bit          prev_rdy [NU];

  logic [31:0] addr_v [NU];
  logic [31:0] wdat_v [NU];
  logic        rd_v   [NU];
  logic        wr_v   [NU];
  logic        den_v  [NU];
  logic        rst_v  [NU];
  wire  [NU-1:0] rdy_v;
  wire  [NU-1:0] err_v;
  wire  [31:0] data_seen [NU];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic int wait_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_unit
    zmips_dmem_if bus ();
    wire [31:0] d_data;

    assign bus.d_addr   = addr_v[g];
    assign bus.d_rd     = rd_v[g];
    assign bus.d_wr     = wr_v[g];
    assign d_data       = den_v[g] ? wdat_v[g] : 32'hzzzz_zzzz;
    assign rdy_v[g]     = bus.d_rdy;
    assign err_v[g]     = bus.d_err;
    assign data_seen[g] = d_data;

    zmips_dmem #(
      .ADDR_W      (10),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .BASE_ADDR   (BASE)
    ) dut (
      .clk    (clk),
      .rst    (rst_v[g]),
      .bus    (bus),
      .d_data (d_data)
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference rules: reads return the last good write to that word address.
  // Errors return 0 on reads and never change memory.
  function automatic bit exp_err(input bit rd, input bit wr, input logic [31:0] a);
    return (rd && wr) || (a % 4 != 0) || (a < BASE) || (a >= BASE + WINDOW);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (rdy_v[u]) begin
        check($sformatf("u%0d_rdy_back_to_back", u), 32'(prev_rdy[u]), 32'd0);
        if (sb.size() == 0 || sb[0].unit != u) begin
          checks++;
          errors++;
          $display("FAIL u%0d_unexpected_rdy: got d_rdy=1 at cycle %0d, expected none", u, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          check({e.name, "_err"}, 32'(err_v[u]), 32'(e.err));
          if (e.chk) check({e.name, "_data"}, data_seen[u], e.data);
        end
      end
      prev_rdy[u] = rdy_v[u];
    end
  end

  // Predict the response and push it onto the scoreboard. The initiator
  // holds its strobe until d_rdy, then releases it after the RESP edge.
  // With chg set, address/data change in the first WAIT cycle.
  task automatic access(input int u, input string name, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chg, input logic [31:0] addr2, input logic [31:0] wdata2);
    exp_t e;
    int   n;
    bit   err;
    int   key;
    @(negedge clk);
    addr_v[u] = addr;
    wdat_v[u] = wdata;
    rd_v[u]   = rd;
    wr_v[u]   = wr;
    den_v[u]  = wr;
    err       = exp_err(rd, wr, addr);
    key       = u * 65536 + int'(addr[15:0]);
    e.unit    = u;
    e.due     = cyc + 1 + wait_of(u);
    e.err     = err;
    e.name    = name;
    e.chk     = 1'b0;
    e.data    = 32'h0;
    if (wr) begin
      e.chk  = 1'b1;
      e.data = chg ? wdata2 : wdata;
      if (!err) model_mem[key] = wdata;
    end else if (err) begin
      e.chk  = 1'b1;
      e.data = 32'h0;
    end else if (model_mem.exists(key)) begin
      e.chk  = 1'b1;
      e.data = model_mem[key];
    end
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (chg && n == 1) begin
        addr_v[u] = addr2;
        wdat_v[u] = wdata2;
      end
    end while (!rdy_v[u] && n < 40);
    if (!rdy_v[u]) check({name, "_timeout"}, 32'(rdy_v[u]), 32'd1);
    @(posedge clk);
    #1;
    rd_v[u]  = 1'b0;
    wr_v[u]  = 1'b0;
    den_v[u] = 1'b0;
  endtask

  task automatic wr_word(input int u, input string name, input logic [31:0] a, input logic [31:0] d);
    access(u, name, 1'b0, 1'b1, a, d, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd_word(input int u, input string name, input logic [31:0] a);
    access(u, name, 1'b1, 1'b0, a, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int c0;
    checks = 0;
    errors = 0;
    for (int u = 0; u < NU; u++) begin
      addr_v[u] = 32'h0;
      wdat_v[u] = 32'h0;
      rd_v[u]   = 1'b0;
      wr_v[u]   = 1'b0;
      den_v[u]  = 1'b0;
      rst_v[u]  = 1'b1;
      prev_rdy[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(rdy_v), 32'd0);
    check("reset_err", 32'(err_v), 32'd0);
    for (int u = 0; u < NU; u++) rst_v[u] = 1'b0;
    @(negedge clk);
    check("post_reset_rdy", 32'(rdy_v), 32'd0);

    // Unit 0, one wait state: basic write then read back
    wr_word(0, "w_cafe", 32'h0000_0010, 32'hCAFE_F00D);
    rd_word(0, "r_cafe", 32'h0000_0010);

    // Errors: misaligned read, out-of-window write aliasing onto word 0
    wr_word(0, "w_zero", 32'h0000_0000, 32'h0BAD_BEEF);
    rd_word(0, "r_misaligned", 32'h0000_0012);
    wr_word(0, "w_out_window", 32'h0000_1000, 32'hDEAD_0001);
    rd_word(0, "r_zero_kept", 32'h0000_0000);
    rd_word(0, "r_top_word", 32'h0000_0FFC);

    // Collision: both strobes set, RAM unchanged, lane left to the initiator
    wr_word(0, "w_x20", 32'h0000_0020, 32'h5555_AAAA);
    access(0, "rw_collision", 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
    rd_word(0, "r_x20_kept", 32'h0000_0020);

    // Unit 1, zero wait states: read strobe held continuously
    wr_word(1, "w_u1", 32'h0000_0008, 32'h0101_F0F0);
    @(negedge clk);
    addr_v[1] = 32'h0000_0008;
    rd_v[1]   = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.unit = 1;
      e.due  = c0 + 2 * k;
      e.err  = 1'b0;
      e.chk  = 1'b1;
      e.data = 32'h0101_F0F0;
      e.name = $sformatf("b2b_%0d", k);
      sb.push_back(e);
    end
    while (cyc < c0 + 8) @(negedge clk);
    @(posedge clk);
    #1;
    rd_v[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Unit 2, three wait states: reset on the second WAIT cycle of a write
    wr_word(2, "w_x40_old", 32'h0000_0040, 32'h0F0F_0F0F);
    @(negedge clk);
    addr_v[2] = 32'h0000_0040;
    wdat_v[2] = 32'hAAAA_5555;
    wr_v[2]   = 1'b1;
    den_v[2]  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_v[2] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[2] = 1'b0;
    wr_v[2]  = 1'b0;
    den_v[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_rdy_%0d", k), 32'(rdy_v[2]), 32'd0);
    end
    rd_word(2, "r_x40_old", 32'h0000_0040);

    // Unit 2: address/data changed during WAIT; the latched pair is written
    wr_word(2, "w_x84", 32'h0000_0084, 32'h8484_8484);
    access(2, "w_x80_chg", 1'b0, 1'b1, 32'h0000_0080, 32'h8080_1111, 1'b1, 32'h0000_0084, 32'hBEEF_2222);
    rd_word(2, "r_x80", 32'h0000_0080);
    rd_word(2, "r_x84", 32'h0000_0084);

    // Unit 0: randomized traffic against the reference memory
    for (int k = 0; k < 16; k++) begin
      wr_word(0, $sformatf("seed_%0d", k), 32'(k * 4 + 32'h100), $urandom);
    end
    for (int k = 0; k < 40; k++) begin
      int          kind;
      bit          rd;
      bit          wr;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      wr   = $urandom_range(0, 1) == 1;
      rd   = !wr;
      a    = 32'(32'h100 + $urandom_range(0, 23) * 4);
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      if (kind == 1) a = 32'(WINDOW + $urandom_range(0, 255) * 4);
      if (kind == 2) begin
        rd = 1'b1;
        wr = 1'b1;
      end
      access(0, $sformatf("rand_%0d", k), rd, wr, a, $urandom, 1'b0, 32'h0, 32'h0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
